remove_h_border_sched: RTL and testbench
========================================

# remove_h_border_sched

Round-robin scheduler and block tracker for the horizontal-border-removal stage. It accepts per-flux block requests (extended block size plus expected output pel count) and arbitrates them onto the single shared `ext_size` write port, tagging each word with its flux. It monitors the stage's output pel writes to detect per-flux block completion. Only one block per flux is outstanding at a time, which matches the stage's consumption of one `ext_size` token per block.

## Interface
Parameters:
- `FLUX`, 2: number of interleaved data fluxes; must be ≥2.
- `DATA_WIDTH_EXT`, 7: width of the block size field.
- `COUNT_WIDTH`, 16: width of the expected/observed pel counters.
- `TAG_WIDTH`, `$clog2(FLUX)`: flux tag width (derived).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  FLUX  per-flux block request.
- `req_size`  in  FLUX*DATA_WIDTH_EXT  per-flux extended block size; flux i occupies slice i.
- `req_count`  in  FLUX*COUNT_WIDTH  per-flux expected output pel count.
- `req_ready`  out  FLUX  combinational grant; a request transfers when valid & ready.
- `ext_din`  out  TAG_WIDTH+DATA_WIDTH_EXT  `{tag, size}` to the ext_size FIFO.
- `ext_write`  out  1  ext_size FIFO write strobe.
- `ext_full`  in  1  ext_size FIFO full.
- `pel_write`  in  1  copy of the stage's output-pel write strobe.
- `pel_tag`  in  TAG_WIDTH  tag field of the stage's output pel word.
- `blk_done`  out  FLUX  one-cycle pulse per completed block.
- `busy`  out  FLUX  flux has a block outstanding.
- `err_overrun`  out  FLUX  sticky: a pel arrived for a flux with no outstanding block.

## Operation
- Per-flux state is IDLE or ACTIVE. Per-flux registers:
  - `expected` (COUNT_WIDTH)
  - `cnt` (COUNT_WIDTH)
  - `done` pulse register
  - `err` sticky register
- Global register: round-robin pointer `rr` (TAG_WIDTH).
- **Eligibility:** flux i is eligible when `req_valid[i]`, state[i]==IDLE and `ext_full`==0.
- **Arbitration:**
  - Search starts at `rr` and wraps modulo FLUX. The first eligible flux is granted.
  - At most one grant per cycle.
  - On a grant, `rr` becomes (granted+1) mod FLUX. With no grant, `rr` holds.
- **Grant to flux g, same cycle:**
  - `req_ready[g]`=1; all other `req_ready` bits are 0.
  - `ext_write`=1.
  - `ext_din`={g, req_size slice g}.
- **Grant to flux g, at the clock edge:**
  - `expected[g]`←req_count slice g; `cnt[g]`←0.
  - If req_count==0: state stays IDLE and `blk_done[g]` pulses next cycle.
  - Otherwise state[g]←ACTIVE.
- **Pel monitoring:**
  - Applies when `pel_write`=1 and `pel_tag`=t, with t<FLUX.
  - If state[t]==ACTIVE: `cnt[t]`←`cnt[t]`+1.
  - If `cnt[t]`+1==`expected[t]`: state[t]←IDLE, `cnt[t]`←0, and `blk_done[t]` pulses next cycle.
  - If state[t]==IDLE: the pel is not counted and `err_overrun[t]` is set (sticky until reset).
  - A tag ≥FLUX is ignored.
- **Outputs:**
  - `busy[i]` = (state[i]==ACTIVE).
  - With no grant, `ext_din`=0.
- **Width rules:**
  - Counters are unsigned and never wrap: completion occurs exactly at `expected`.
  - `req_size` passes through unmodified; any −1 adjustment is done by the downstream stage.

## Timing
- **Reset:** every state is IDLE, `cnt`/`expected`=0, `rr`=0, all outputs 0. A reset asserted mid-block discards the outstanding block with no `blk_done`.
- **Grant latency:** combinational. `req_ready`/`ext_write` assert in the same cycle as an eligible `req_valid`.
- **Completion latency:** `blk_done` is high during the cycle after the edge that samples the final pel. `busy` is 0 in that same cycle.
- **Re-issue after completion:** the flux is IDLE in the `blk_done` cycle, so a new grant for it may occur in that same cycle. Back-to-back blocks therefore have a 1-cycle gap between the last pel and the next `ext_write`.
- **Full FIFO:** `ext_full`=1 blocks all grants and `rr` holds. Requesters must keep `req_valid`/data stable until `req_ready`.
- **Simultaneous events:**
  - A pel for flux i and a grant to flux j≠i are independent.
  - A grant and a final pel for the same flux cannot coincide, because a granted flux must be IDLE.

## Test plan
- **Single block:** FLUX=2, reset, then req flux0 size=16 count=4, `ext_full`=0.
  - Same cycle: `ext_write`=1, `ext_din`={0,16}.
  - 4 pels with tag 0: `blk_done[0]` pulses 1 cycle after the 4th; `busy[0]` falls in that cycle.
- **Fairness:** both fluxes request continuously with count=1, and each pel is returned the cycle after its grant.
  - Grants alternate 0,1,0,1.
  - No flux is granted twice while the other is eligible.
- **Backpressure:** hold `ext_full`=1 for 5 cycles with both requests valid.
  - No `ext_write` and no `req_ready` during those cycles.
  - On release, flux0 is granted first (`rr`=0).
- **Interleaved pels:** flux0 count=3 and flux1 count=2, with pel tags 0,1,0,1,0.
  - `blk_done[1]` after the 4th pel, `blk_done[0]` after the 5th.
  - `err_overrun`=0.
- **Overrun and zero count:**
  - A pel with tag 1 while flux1 is IDLE sets `err_overrun[1]`=1, which stays set.
  - A flux0 request with count=0 gives `blk_done[0]` the next cycle, with `busy[0]` never asserted.
- **Reset mid-block:** flux0 count=10, 3 pels, then `rst` for 1 cycle.
  - All outputs are 0 and there is no `blk_done`.
  - A new request is granted immediately after reset.

Source files
------------

// File: rtl/remove_h_border_sched_if.sv
// Request, ext_size write and pel-monitor signals of the horizontal-border-removal scheduler.
interface remove_h_border_sched_if #(
   parameter int unsigned FLUX           = 2,
   parameter int unsigned DATA_WIDTH_EXT = 7,
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter int unsigned TAG_WIDTH      = $clog2(FLUX)
);
   logic [FLUX-1:0]                     req_valid;
   logic [FLUX*DATA_WIDTH_EXT-1:0]      req_size;
   logic [FLUX*COUNT_WIDTH-1:0]         req_count;
   logic [FLUX-1:0]                     req_ready;
   logic [TAG_WIDTH+DATA_WIDTH_EXT-1:0] ext_din;
   logic                                ext_write;
   logic                                ext_full;
   logic                                pel_write;
   logic [TAG_WIDTH-1:0]                pel_tag;
   logic [FLUX-1:0]                     blk_done;
   logic [FLUX-1:0]                     busy;
   logic [FLUX-1:0]                     err_overrun;

   // Requesters / FIFO / pel source side
   modport master (
      output req_valid, req_size, req_count, ext_full, pel_write, pel_tag,
      input  req_ready, ext_din, ext_write, blk_done, busy, err_overrun
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_size, req_count, ext_full, pel_write, pel_tag,
      output req_ready, ext_din, ext_write, blk_done, busy, err_overrun
   );
endinterface

// File: rtl/remove_h_border_sched.sv
// Round-robin arbiter of per-flux block requests onto the shared ext_size port,
// with per-flux pel counting to detect block completion.
module remove_h_border_sched #(
   parameter int unsigned FLUX           = 2,
   parameter int unsigned DATA_WIDTH_EXT = 7,
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter int unsigned TAG_WIDTH      = $clog2(FLUX)
) (
   input  logic                   clk,
   input  logic                   rst,
   remove_h_border_sched_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} flux_state_e;

   flux_state_e            state_q [FLUX];
   flux_state_e            state_d [FLUX];
   logic [COUNT_WIDTH-1:0] cnt_q   [FLUX];
   logic [COUNT_WIDTH-1:0] cnt_d   [FLUX];
   logic [COUNT_WIDTH-1:0] exp_q   [FLUX];
   logic [COUNT_WIDTH-1:0] exp_d   [FLUX];
   logic [FLUX-1:0]        done_q, done_d;
   logic [FLUX-1:0]        err_q, err_d;
   logic [TAG_WIDTH-1:0]   rr_q, rr_d;

   logic [FLUX-1:0]                     req_ready_c;
   logic                                ext_write_c;
   logic [TAG_WIDTH+DATA_WIDTH_EXT-1:0] ext_din_c;

   // State register; synchronous reset drops any outstanding block silently
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(FLUX); i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            exp_q[i]   <= '0;
         end
         done_q <= '0;
         err_q  <= '0;
         rr_q   <= '0;
      end else begin
         for (int i = 0; i < int'(FLUX); i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            exp_q[i]   <= exp_d[i];
         end
         done_q <= done_d;
         err_q  <= err_d;
         rr_q   <= rr_d;
      end
   end

   // Arbitration, grant side effects and pel monitoring
   always_comb begin
      logic                 found;
      logic [TAG_WIDTH-1:0] gtag;
      logic [TAG_WIDTH-1:0] ctag;
      logic [TAG_WIDTH-1:0] ptag;
      int unsigned          idx;

      for (int i = 0; i < int'(FLUX); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         exp_d[i]   = exp_q[i];
      end
      done_d      = '0;
      err_d       = err_q;
      rr_d        = rr_q;
      req_ready_c = '0;
      ext_write_c = 1'b0;
      ext_din_c   = '0;
      found       = 1'b0;
      gtag        = '0;
      ctag        = '0;
      ptag        = bus.pel_tag;
      idx         = 0;

      // First eligible flux at or after the round-robin pointer wins
      for (int unsigned k = 0; k < FLUX; k++) begin
         idx  = (32'(rr_q) + k) % FLUX;
         ctag = TAG_WIDTH'(idx);
         if (!found && !rst && !bus.ext_full && bus.req_valid[ctag] && state_q[ctag] == IDLE) begin
            found = 1'b1;
            gtag  = ctag;
         end
      end

      if (found) begin
         req_ready_c[gtag] = 1'b1;
         ext_write_c       = 1'b1;
         ext_din_c         = {gtag, bus.req_size[32'(gtag)*DATA_WIDTH_EXT +: DATA_WIDTH_EXT]};
         exp_d[gtag]       = bus.req_count[32'(gtag)*COUNT_WIDTH +: COUNT_WIDTH];
         cnt_d[gtag]       = '0;
         if (bus.req_count[32'(gtag)*COUNT_WIDTH +: COUNT_WIDTH] == '0) begin
            done_d[gtag] = 1'b1;
         end else begin
            state_d[gtag] = ACTIVE;
         end
         rr_d = TAG_WIDTH'((32'(gtag) + 1) % FLUX);
      end

      // A granted flux is IDLE, so its grant never collides with its final pel
      if (bus.pel_write && (32'(ptag) < FLUX)) begin
         if (state_q[ptag] == ACTIVE) begin
            if (cnt_q[ptag] + COUNT_WIDTH'(1) == exp_q[ptag]) begin
               state_d[ptag] = IDLE;
               cnt_d[ptag]   = '0;
               done_d[ptag]  = 1'b1;
            end else begin
               cnt_d[ptag] = cnt_q[ptag] + COUNT_WIDTH'(1);
            end
         end else begin
            err_d[ptag] = 1'b1;
         end
      end
   end

   // Status outputs decoded from registered state
   always_comb begin
      for (int i = 0; i < int'(FLUX); i++) begin
         bus.busy[i] = (state_q[i] == ACTIVE);
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.ext_write   = ext_write_c;
   assign bus.ext_din     = ext_din_c;
   assign bus.blk_done    = done_q;
   assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_remove_h_border_sched.sv
// Directed bench for remove_h_border_sched (FLUX=2).
module tb_remove_h_border_sched;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   remove_h_border_sched_if #(.FLUX(2), .DATA_WIDTH_EXT(7), .COUNT_WIDTH(16)) bus ();

   remove_h_border_sched #(.FLUX(2), .DATA_WIDTH_EXT(7), .COUNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_size  = '0;
      bus.req_count = '0;
      bus.ext_full  = 1'b0;
      bus.pel_write = 1'b0;
      bus.pel_tag   = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", bus.busy); end
      checks++;
      if (bus.blk_done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", bus.blk_done); end
      checks++;
      if (bus.err_overrun !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", bus.err_overrun); end
      checks++;
      if (bus.ext_write !== 1'b0 || bus.req_ready !== 2'b00 || bus.ext_din !== 8'h00) begin
         errors++;
         $display("FAIL reset_grant: got write=%b ready=%b din=%h expected 0/00/00", bus.ext_write, bus.req_ready, bus.ext_din);
      end
   endtask

   task automatic test_single_block();
      do_reset();
      bus.req_valid = 2'b01;
      bus.req_size  = {7'd0, 7'd16};
      bus.req_count = {16'd0, 16'd4};
      #1;
      checks++;
      if (bus.ext_write !== 1'b1 || bus.ext_din !== 8'h10 || bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_grant: got write=%b din=%h ready=%b expected 1/10/01", bus.ext_write, bus.ext_din, bus.req_ready);
      end
      step();
      bus.req_valid = 2'b00;
      checks++;
      if (bus.busy !== 2'b01) begin errors++; $display("FAIL single_busy: got %b expected 01", bus.busy); end
      for (int i = 0; i < 4; i++) begin
         bus.pel_write = 1'b1;
         bus.pel_tag   = 1'b0;
         step();
         if (i < 3) begin
            checks++;
            if (bus.blk_done !== 2'b00 || bus.busy !== 2'b01) begin
               errors++;
               $display("FAIL single_early_done: pel %0d got done=%b busy=%b expected 00/01", i, bus.blk_done, bus.busy);
            end
         end
      end
      bus.pel_write = 1'b0;
      checks++;
      if (bus.blk_done !== 2'b01 || bus.busy !== 2'b00) begin
         errors++;
         $display("FAIL single_done: got done=%b busy=%b expected 01/00", bus.blk_done, bus.busy);
      end
      step();
      checks++;
      if (bus.blk_done !== 2'b00) begin errors++; $display("FAIL single_pulse: got %b expected 00", bus.blk_done); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_ready;
      logic [1:0] exp_done;
      logic [7:0] exp_din;
      do_reset();
      bus.req_size  = {7'd4, 7'd3};
      bus.req_count = {16'd1, 16'd1};
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 2'b11;
         bus.pel_write = (i > 0);
         bus.pel_tag   = (i > 0) ? 1'((i - 1) % 2) : 1'b0;
         exp_ready     = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_din       = (i % 2 == 0) ? 8'h03 : 8'h84;
         exp_done      = (i < 2) ? 2'b00 : (((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
         #1;
         checks++;
         if (bus.req_ready !== exp_ready || bus.ext_write !== 1'b1 || bus.ext_din !== exp_din) begin
            errors++;
            $display("FAIL fair_grant: cycle %0d got ready=%b write=%b din=%h expected %b/1/%h",
                     i, bus.req_ready, bus.ext_write, bus.ext_din, exp_ready, exp_din);
         end
         checks++;
         if (bus.blk_done !== exp_done) begin
            errors++;
            $display("FAIL fair_done: cycle %0d got %b expected %b", i, bus.blk_done, exp_done);
         end
         step();
      end
      bus.req_valid = 2'b00;
      bus.pel_write = 1'b1;
      bus.pel_tag   = 1'b1;
      checks++;
      if (bus.blk_done !== 2'b01) begin errors++; $display("FAIL fair_done_tail0: got %b expected 01", bus.blk_done); end
      step();
      bus.pel_write = 1'b0;
      checks++;
      if (bus.blk_done !== 2'b10 || bus.busy !== 2'b00) begin
         errors++;
         $display("FAIL fair_done_tail1: got done=%b busy=%b expected 10/00", bus.blk_done, bus.busy);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req_valid = 2'b11;
      bus.req_size  = {7'd9, 7'd5};
      bus.req_count = {16'd2, 16'd2};
      bus.ext_full  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.ext_write !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_blocked: cycle %0d got write=%b ready=%b expected 0/00", i, bus.ext_write, bus.req_ready);
         end
         step();
      end
      bus.ext_full = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01 || bus.ext_din !== 8'h05 || bus.ext_write !== 1'b1) begin
         errors++;
         $display("FAIL bp_release0: got ready=%b din=%h write=%b expected 01/05/1", bus.req_ready, bus.ext_din, bus.ext_write);
      end
      step();
      #1;
      checks++;
      if (bus.req_ready !== 2'b10 || bus.ext_din !== 8'h89 || bus.ext_write !== 1'b1) begin
         errors++;
         $display("FAIL bp_release1: got ready=%b din=%h write=%b expected 10/89/1", bus.req_ready, bus.ext_din, bus.ext_write);
      end
      step();
      bus.req_valid = 2'b00;
      checks++;
      if (bus.busy !== 2'b11) begin errors++; $display("FAIL bp_busy: got %b expected 11", bus.busy); end
   endtask

   task automatic test_interleaved();
      logic [1:0] exp_done [5];
      exp_done = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
      do_reset();
      bus.req_size  = {7'd2, 7'd1};
      bus.req_count = {16'd2, 16'd3};
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = 2'b10;
      step();
      bus.req_valid = 2'b00;
      checks++;
      if (bus.busy !== 2'b11) begin errors++; $display("FAIL il_busy: got %b expected 11", bus.busy); end
      for (int i = 0; i < 5; i++) begin
         bus.pel_write = 1'b1;
         bus.pel_tag   = 1'(i % 2);
         step();
         checks++;
         if (bus.blk_done !== exp_done[i]) begin
            errors++;
            $display("FAIL il_done: pel %0d got %b expected %b", i, bus.blk_done, exp_done[i]);
         end
      end
      bus.pel_write = 1'b0;
      checks++;
      if (bus.err_overrun !== 2'b00 || bus.busy !== 2'b00) begin
         errors++;
         $display("FAIL il_final: got err=%b busy=%b expected 00/00", bus.err_overrun, bus.busy);
      end
   endtask

   task automatic test_overrun_zero();
      do_reset();
      bus.pel_write = 1'b1;
      bus.pel_tag   = 1'b1;
      step();
      bus.pel_write = 1'b0;
      checks++;
      if (bus.err_overrun !== 2'b10) begin errors++; $display("FAIL ovr_set: got %b expected 10", bus.err_overrun); end
      bus.req_valid = 2'b01;
      bus.req_size  = {7'd0, 7'd7};
      bus.req_count = {16'd0, 16'd0};
      #1;
      checks++;
      if (bus.ext_write !== 1'b1 || bus.ext_din !== 8'h07) begin
         errors++;
         $display("FAIL zero_grant: got write=%b din=%h expected 1/07", bus.ext_write, bus.ext_din);
      end
      step();
      bus.req_valid = 2'b00;
      checks++;
      if (bus.blk_done !== 2'b01 || bus.busy !== 2'b00) begin
         errors++;
         $display("FAIL zero_done: got done=%b busy=%b expected 01/00", bus.blk_done, bus.busy);
      end
      step();
      checks++;
      if (bus.blk_done !== 2'b00 || bus.busy !== 2'b00 || bus.err_overrun !== 2'b10) begin
         errors++;
         $display("FAIL zero_after: got done=%b busy=%b err=%b expected 00/00/10", bus.blk_done, bus.busy, bus.err_overrun);
      end
   endtask

   task automatic test_reset_mid_block();
      do_reset();
      bus.req_valid = 2'b01;
      bus.req_size  = {7'd3, 7'd12};
      bus.req_count = {16'd1, 16'd10};
      step();
      bus.req_valid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         bus.pel_write = 1'b1;
         bus.pel_tag   = 1'b0;
         step();
      end
      bus.pel_write = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.busy !== 2'b00 || bus.blk_done !== 2'b00 || bus.err_overrun !== 2'b00) begin
         errors++;
         $display("FAIL mid_rst_out: got busy=%b done=%b err=%b expected 00/00/00", bus.busy, bus.blk_done, bus.err_overrun);
      end
      bus.req_valid = 2'b10;
      #1;
      checks++;
      if (bus.req_ready !== 2'b10 || bus.ext_write !== 1'b1 || bus.ext_din !== 8'h83) begin
         errors++;
         $display("FAIL mid_rst_regrant: got ready=%b write=%b din=%h expected 10/1/83", bus.req_ready, bus.ext_write, bus.ext_din);
      end
      step();
      bus.req_valid = 2'b00;
      checks++;
      if (bus.blk_done !== 2'b00 || bus.busy !== 2'b10) begin
         errors++;
         $display("FAIL mid_rst_after: got done=%b busy=%b expected 00/10", bus.blk_done, bus.busy);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_single_block();
      test_fairness();
      test_backpressure();
      test_interleaved();
      test_overrun_zero();
      test_reset_mid_block();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
